load_store_unit: RTL

- Memory-access stage directly upstream of the word-addressed data memory; accepts one load/store request at a time from the pipeline.
- Word stores go straight through; byte/halfword stores become read-modify-write sequences; load results are sign/zero-extended.
- Misaligned and illegal requests are rejected with no memory access.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - SZ_* request size encodings
//   - state_t FSM state encoding
//   - is_misaligned(): alignment check for a size / low address pair
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_t;

  // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and data-memory bus.
//   req_*  : request from the pipeline (valid/ready handshake)
//   resp_* : one-cycle completion pulse with load data / error
//   mem_*  : word-addressed memory port (mem_rdata is combinational)
// Modports: slave = the load/store unit, master = pipeline + memory side.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane handling (little-endian).
//   size, is_unsigned, lane : captured request attributes (lane = addr[1:0])
//   word                    : word read from memory
//   wdata                   : right-aligned store data
//   load_data               : selected lane, sign/zero extended
//   merge_data              : word with target lane(s) replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic        [7:0]  b;
  logic        [15:0] h;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;

  always_comb begin
    b   = word[{lane, 3'b000} +: 8];
    h   = word[{lane[1], 4'b0000} +: 16];
    b_s = signed'(b);
    h_s = signed'(h);

    case (size)
      SZ_BYTE: load_data = is_unsigned ? DATA_W'(b) : DATA_W'(b_s);
      SZ_HALF: load_data = is_unsigned ? DATA_W'(h) : DATA_W'(h_s);
      default: load_data = word;
    endcase

    merge_data = word;
    case (size)
      SZ_BYTE: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage in front of a word-addressed memory.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : load_store_unit_if.slave (request, response and memory port)
// Word stores write directly; byte/half stores read-modify-write; loads are
// lane-extracted and extended. Misaligned or illegal-size requests respond
// with resp_err and never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  load_store_unit_if.slave       bus
);

  state_t            state;
  logic [1:0]        a_size;
  logic              a_unsigned;
  logic [1:0]        a_lane;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic              req_bad;

  assign bus.req_ready = (state == ST_IDLE);
  assign req_bad       = (bus.req_size == SZ_ILL) || is_misaligned(bus.req_size, bus.req_addr[1:0]);

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size        (a_size),
    .is_unsigned (a_unsigned),
    .lane        (a_lane),
    .word        (bus.mem_rdata),
    .wdata       (a_wdata),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // All outputs are registered on the transition into the state that uses
  // them, so each state sees its mem_* controls from its first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      a_size         <= SZ_BYTE;
      a_unsigned     <= 1'b0;
      a_lane         <= 2'b00;
      a_wdata        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_addr   <= '0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            a_size     <= bus.req_size;
            a_unsigned <= bus.req_unsigned;
            a_lane     <= bus.req_addr[1:0];
            a_wdata    <= bus.req_wdata;
            if (req_bad) begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (!bus.req_write) begin
                state        <= ST_LOAD;
                bus.mem_read <= 1'b1;
              end else if (bus.req_size == SZ_WORD) begin
                state         <= ST_WRITE;
                bus.mem_write <= 1'b1;
                bus.mem_wdata <= bus.req_wdata;
              end else begin
                state        <= ST_RMW_RD;
                bus.mem_read <= 1'b1;
              end
            end
          end
        end
        ST_LOAD: begin
          state          <= ST_RESP;
          bus.mem_read   <= 1'b0;
          bus.mem_addr   <= '0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= load_data;
        end
        ST_RMW_RD: begin
          // Merge the read word with the store lane(s) straight into the
          // write-data register used by the following write cycle.
          state         <= ST_RMW_WR;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b1;
          bus.mem_wdata <= merge_data;
        end
        ST_WRITE, ST_RMW_WR: begin
          state          <= ST_RESP;
          bus.mem_write  <= 1'b0;
          bus.mem_wdata  <= '0;
          bus.mem_addr   <= '0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
